// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryption core: one round step per clock, key schedule expanded on the fly.
// Optional macro AES_KEY_CACHE_EN skips key expansion when the key matches the last expanded one.

module AesGfInv (
    input  logic [7:0] a_i,
    output logic [7:0] inv_o
);
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 = a^2 * a^4 * ... * a^128, which also maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gfInv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gfMul(sq, sq);
            r  = gfMul(r, sq);
        end
        return r;
    endfunction

    assign inv_o = gfInv(a_i);
endmodule

module AesSbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    logic [7:0] inv;

    AesGfInv uInv (.a_i(in_i), .inv_o(inv));

    assign out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module AesInvSbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    logic [7:0] affInv;

    assign affInv = {in_i[6:0], in_i[7]} ^ {in_i[4:0], in_i[7:5]} ^ {in_i[1:0], in_i[7:2]} ^ 8'h05;

    AesGfInv uInv (.a_i(affInv), .inv_o(out_o));
endmodule

module aes_decrypt_core #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         AES_START,
    input  logic [127:0] AES_KEY,
    input  logic [127:0] AES_MSG_ENC,
    output logic         AES_DONE,
    output logic [127:0] AES_MSG_DEC
);
    if (NUM_ROUNDS != 10) begin : gBadRounds
        $error("aes_decrypt_core supports only NUM_ROUNDS = 10");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [3:0] {
        IDLE, KEYEXP, ARK0, RND_ISR, RND_ISB, RND_ARK, RND_IMC,
        FIN_ISR, FIN_ISB, FIN_ARK, DONE
    } fsm_e;

    fsm_e         fsmQ, fsmD;
    logic [127:0] dataQ, dataD;
    logic [127:0] rkQ [0:NUM_ROUNDS];
    logic [127:0] rkD [0:NUM_ROUNDS];
    logic [3:0]   roundQ, roundD;
    logic [127:0] msgDecQ, msgDecD;
`ifdef AES_KEY_CACHE_EN
    logic         keyValidQ, keyValidD;
    logic [127:0] keyCacheQ, keyCacheD;
`endif

    logic [127:0] prevRk, curRk, nextRk, invSubOut;
    logic [31:0]  rotWord, subWord, keyTemp;

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Row r of the output takes column (c - r) mod 4 of the input
    function automatic logic [127:0] invShiftRows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c - r + 4) % 4) - 8*r -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] invMixColumns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09);
            o[119 - 32*c -: 8] = gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        prevRk = '0;
        curRk  = '0;
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            if (roundQ == 4'(i))     curRk  = rkQ[i];
            if (roundQ == 4'(i + 1)) prevRk = rkQ[i];
        end
    end

    assign rotWord = {prevRk[23:0], prevRk[31:24]};

    for (genvar b = 0; b < 4; b++) begin : gKeySbox
        AesSbox uSbox (.in_i(rotWord[31 - 8*b -: 8]), .out_o(subWord[31 - 8*b -: 8]));
    end

    assign keyTemp        = subWord ^ {rcon(roundQ), 24'h000000};
    assign nextRk[127:96] = prevRk[127:96] ^ keyTemp;
    assign nextRk[95:64]  = prevRk[95:64]  ^ nextRk[127:96];
    assign nextRk[63:32]  = prevRk[63:32]  ^ nextRk[95:64];
    assign nextRk[31:0]   = prevRk[31:0]   ^ nextRk[63:32];

    for (genvar b = 0; b < 16; b++) begin : gStateSbox
        AesInvSbox uInvSbox (.in_i(dataQ[127 - 8*b -: 8]), .out_o(invSubOut[127 - 8*b -: 8]));
    end

    always_comb begin
        fsmD    = fsmQ;
        dataD   = dataQ;
        rkD     = rkQ;
        roundD  = roundQ;
        msgDecD = msgDecQ;
`ifdef AES_KEY_CACHE_EN
        keyValidD = keyValidQ;
        keyCacheD = keyCacheQ;
`endif
        case (fsmQ)
            IDLE: begin
                if (AES_START) begin
                    rkD[0] = AES_KEY;
                    dataD  = AES_MSG_ENC;
                    roundD = 4'd1;
                    fsmD   = KEYEXP;
`ifdef AES_KEY_CACHE_EN
                    // A matching key means rkQ already holds its full schedule
                    keyCacheD = AES_KEY;
                    if (keyValidQ && (AES_KEY == keyCacheQ)) fsmD = ARK0;
                    else                                     keyValidD = 1'b0;
`endif
                end
            end
            KEYEXP: begin
                for (int i = 1; i <= NUM_ROUNDS; i++) begin
                    if (roundQ == 4'(i)) rkD[i] = nextRk;
                end
                roundD = roundQ + 4'd1;
                if (roundQ == LAST_ROUND) begin
                    fsmD = ARK0;
`ifdef AES_KEY_CACHE_EN
                    keyValidD = 1'b1;
`endif
                end
            end
            ARK0: begin
                dataD  = dataQ ^ rkQ[NUM_ROUNDS];
                roundD = LAST_ROUND - 4'd1;
                fsmD   = RND_ISR;
            end
            RND_ISR: begin
                dataD = invShiftRows(dataQ);
                fsmD  = RND_ISB;
            end
            RND_ISB: begin
                dataD = invSubOut;
                fsmD  = RND_ARK;
            end
            RND_ARK: begin
                dataD = dataQ ^ curRk;
                fsmD  = RND_IMC;
            end
            RND_IMC: begin
                dataD = invMixColumns(dataQ);
                if (roundQ == 4'd1) begin
                    fsmD = FIN_ISR;
                end else begin
                    roundD = roundQ - 4'd1;
                    fsmD   = RND_ISR;
                end
            end
            FIN_ISR: begin
                dataD = invShiftRows(dataQ);
                fsmD  = FIN_ISB;
            end
            FIN_ISB: begin
                dataD = invSubOut;
                fsmD  = FIN_ARK;
            end
            FIN_ARK: begin
                dataD   = dataQ ^ rkQ[0];
                msgDecD = dataQ ^ rkQ[0];
                fsmD    = DONE;
            end
            DONE: begin
                if (!AES_START) fsmD = IDLE;
            end
            default: fsmD = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fsmQ    <= IDLE;
            dataQ   <= '0;
            rkQ     <= '{default: '0};
            roundQ  <= '0;
            msgDecQ <= '0;
`ifdef AES_KEY_CACHE_EN
            keyValidQ <= 1'b0;
            keyCacheQ <= '0;
`endif
        end else begin
            fsmQ    <= fsmD;
            dataQ   <= dataD;
            rkQ     <= rkD;
            roundQ  <= roundD;
            msgDecQ <= msgDecD;
`ifdef AES_KEY_CACHE_EN
            keyValidQ <= keyValidD;
            keyCacheQ <= keyCacheD;
`endif
        end
    end

    assign AES_DONE    = (fsmQ == DONE);
    assign AES_MSG_DEC = msgDecQ;
endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed bench for aes_decrypt_core using FIPS-197 vectors, handshake, reset and key-cache cases.
// Expected latency for repeated keys follows AES_KEY_CACHE_EN.

module tb_aes_decrypt_core;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_ENC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_ENC  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES_KEY_CACHE_EN
    localparam int REPEAT_LATENCY = 40;
`else
    localparam int REPEAT_LATENCY = 50;
`endif

    logic         clock;
    logic         resetN;
    logic         aesStart;
    logic [127:0] aesKey;
    logic [127:0] aesMsgEnc;
    logic         aesDone;
    logic [127:0] aesMsgDec;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int edges;
    int changed;

    aes_decrypt_core dut (
        .CLK         (clock),
        .RESET       (resetN),
        .AES_START   (aesStart),
        .AES_KEY     (aesKey),
        .AES_MSG_ENC (aesMsgEnc),
        .AES_DONE    (aesDone),
        .AES_MSG_DEC (aesMsgDec)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Launches a run and counts edges after the start-sampling edge until AES_DONE rises
    task automatic applyStimulus(input logic [127:0] key, input logic [127:0] enc,
                                 input bit holdStart, input bit churn,
                                 output int doneEdges, output int outChanges);
        logic [127:0] held;
        @(negedge clock);
        aesKey    = key;
        aesMsgEnc = enc;
        aesStart  = 1'b1;
        held      = aesMsgDec;
        @(posedge clock);
        #1;
        if (!holdStart) aesStart = 1'b0;
        doneEdges  = 0;
        outChanges = 0;
        while (doneEdges < 200) begin
            @(posedge clock);
            doneEdges++;
            #1;
            if (churn && doneEdges == 1) begin
                aesKey    = '1;
                aesMsgEnc = '1;
            end
            if (aesDone) break;
            if (aesMsgDec !== held) outChanges++;
        end
    endtask

    initial begin
        resetN    = 1'b0;
        aesStart  = 1'b0;
        aesKey    = '0;
        aesMsgEnc = '0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_done", 128'(aesDone), 128'(0));
        checkOutput("reset_msg", aesMsgDec, '0);
        @(negedge clock);
        resetN = 1'b1;

        applyStimulus(C1_KEY, C1_ENC, 1'b1, 1'b0, edges, changed);
        checkOutput("c1_latency", 128'(edges), 128'(50));
        checkOutput("c1_plaintext", aesMsgDec, C1_PT);
        repeat (20) @(posedge clock);
        #1;
        checkOutput("hold_done", 128'(aesDone), 128'(1));
        aesStart = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("drop_done", 128'(aesDone), 128'(0));

        applyStimulus(B_KEY, B_ENC, 1'b0, 1'b0, edges, changed);
        checkOutput("b_latency", 128'(edges), 128'(50));
        checkOutput("b_plaintext", aesMsgDec, B_PT);
        checkOutput("b_prior_held", 128'(changed), 128'(0));
        @(posedge clock);
        #1;
        checkOutput("pulse_done_one_cycle", 128'(aesDone), 128'(0));

        applyStimulus(B_KEY, B_ENC, 1'b0, 1'b1, edges, changed);
        checkOutput("churn_latency", 128'(edges), 128'(REPEAT_LATENCY));
        checkOutput("churn_plaintext", aesMsgDec, B_PT);
        @(posedge clock);

        @(negedge clock);
        aesKey    = C1_KEY;
        aesMsgEnc = C1_ENC;
        aesStart  = 1'b1;
        @(posedge clock);
        #1;
        aesStart = 1'b0;
        repeat (25) @(posedge clock);
        #3;
        resetN = 1'b0;
        #1;
        checkOutput("midrun_reset_done", 128'(aesDone), 128'(0));
        checkOutput("midrun_reset_msg", aesMsgDec, '0);
        @(negedge clock);
        resetN = 1'b1;

        applyStimulus(C1_KEY, C1_ENC, 1'b0, 1'b0, edges, changed);
        checkOutput("restart_latency", 128'(edges), 128'(50));
        checkOutput("restart_plaintext", aesMsgDec, C1_PT);
        @(posedge clock);

        applyStimulus(C1_KEY, C1_ENC, 1'b0, 1'b0, edges, changed);
        checkOutput("repeat_key_latency", 128'(edges), 128'(REPEAT_LATENCY));
        checkOutput("repeat_key_plaintext", aesMsgDec, C1_PT);
        @(posedge clock);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
